uart_rx: RTL and testbench

Serial-to-byte receiver for the 8N1 UART line used across the lab designs. It decodes the serial stream that the line-side blocks (delay stages, taps, and pass-through paths) carry. It samples the idle-high line at the centre of each bit and delivers bytes over a valid/ready handshake. Framing and overrun conditions are flagged, so a downstream tap or man-in-the-middle stage can inspect or modify traffic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, bit-count constant
// and the clock-cycles-per-bit helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic int cyc_count(
        input int system_clock,
        input int baud_rate
    );
        return system_clock / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-level valid/ready handshake between the UART receiver and its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {2{RST_VAL}};
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled 8N1 (or 8E1 with UART_RX_PARITY_EN) byte
// delivery over valid/ready, with framing/parity/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CYC_COUNT    = cyc_count(SYSTEM_CLOCK, BAUD_RATE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.master  byte_if,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CYC_COUNT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_FULL = CW'(CYC_COUNT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CYC_COUNT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 line;

`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`else
    assign parity_err = 1'b0;
`endif

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            byte_if.data  <= '0;
            byte_if.valid <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err    <= 1'b0;
            par_bit       <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (byte_if.valid && byte_if.ready) begin
                byte_if.valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!line) begin
                        cnt   <= CNT_HALF;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == '0) begin
                        if (line) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt     <= CNT_FULL;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == '0) begin
                        shreg <= {line, shreg[DATA_BITS-1:1]};
                        cnt   <= CNT_FULL;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        par_bit <= line;
                        cnt     <= CNT_FULL;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == '0) begin
                        frame_err <= !line;
`ifdef UART_RX_PARITY_EN
                        parity_err <= ^{shreg, par_bit};
`endif
                        // A full holding register keeps the old byte
                        if (!byte_if.valid || byte_if.ready) begin
                            byte_if.data  <= shreg;
                            byte_if.valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        state <= line ? IDLE : WAIT_IDLE;
                        busy  <= !line;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (line) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk per bit; define UART_RX_PARITY_EN
// for the parity scenario.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CYC = 16;

    logic clk;
    logic rst;
    logic rxd;
    logic frame_err;
    logic parity_err;
    logic overrun;
    logic busy;

    uart_rx_if bus ();

    uart_rx #(
        .SYSTEM_CLOCK (16),
        .BAUD_RATE    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_if    (bus),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int acc_n  = 0;
    int vcyc_n = 0;
    int fe_n   = 0;
    int pe_n   = 0;
    int ov_n   = 0;
    logic [7:0] last_acc = 8'h00;

    // Pre-edge values: every handshake and every one-cycle pulse seen once
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.valid && bus.ready) begin
                acc_n    <= acc_n + 1;
                last_acc <= bus.data;
            end
            if (bus.valid)  vcyc_n <= vcyc_n + 1;
            if (frame_err)  fe_n   <= fe_n + 1;
            if (parity_err) pe_n   <= pe_n + 1;
            if (overrun)    ov_n   <= ov_n + 1;
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(
        input logic [7:0] b,
        input logic       stop,
        input logic       par_flip
    );
        rxd = 1'b0;
        repeat (CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CYC) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        repeat (CYC) @(negedge clk);
`endif
        rxd = stop;
        repeat (CYC) @(negedge clk);
    endtask

    int a0, v0, f0, o0;

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_perr", 32'(parity_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        idle(5);

        // plain frame, consumer ready
        a0 = acc_n; v0 = vcyc_n;
        send_frame(8'h55, 1'b1, 1'b0);
        idle(4);
        check("f55_acc", 32'(acc_n - a0), 1);
        check("f55_data", 32'(last_acc), 32'h55);
        check("f55_vcyc", 32'(vcyc_n - v0), 1);
        check("f55_ferr", 32'(fe_n), 0);
        check("f55_ovr", 32'(ov_n), 0);
        check("f55_busy", 32'(busy), 0);

        // overrun: second byte dropped while first is held
        bus.ready = 1'b0;
        a0 = acc_n; o0 = ov_n;
        send_frame(8'hA3, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        check("ovr_pulse", 32'(ov_n - o0), 1);
        check("ovr_data", 32'(bus.data), 32'hA3);
        check("ovr_valid", 32'(bus.valid), 1);
        bus.ready = 1'b1;
        @(negedge clk);
        check("ovr_vclr", 32'(bus.valid), 0);
        idle(4);
        check("ovr_acc", 32'(acc_n - a0), 1);
        check("ovr_last", 32'(last_acc), 32'hA3);

        // 4-cycle glitch is a false start
        a0 = acc_n;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        check("gl_busy_hi", 32'(busy), 1);
        idle(12);
        check("gl_busy_lo", 32'(busy), 0);
        check("gl_acc", 32'(acc_n - a0), 0);
        check("gl_ferr", 32'(fe_n), 0);

        // low stop bit then break
        a0 = acc_n; f0 = fe_n;
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_ferr", 32'(fe_n - f0), 1);
        check("brk_acc", 32'(acc_n - a0), 1);
        check("brk_data", 32'(last_acc), 32'h00);
        check("brk_busy", 32'(busy), 1);
        idle(5);
        check("brk_idle", 32'(busy), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        check("brk_acc2", 32'(acc_n - a0), 2);
        check("brk_data2", 32'(last_acc), 32'h81);
        check("brk_ferr2", 32'(fe_n - f0), 1);

        // reset during data bit 4
        a0 = acc_n;
        rxd = 1'b0;
        repeat (CYC) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * CYC + CYC / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_data", 32'(bus.data), 32'h00);
        check("mr_valid", 32'(bus.valid), 0);
        check("mr_busy", 32'(busy), 0);
        rst = 1'b0;
        idle(4 * CYC);
        check("mr_acc", 32'(acc_n - a0), 0);
        check("mr_busy2", 32'(busy), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        check("mr_acc2", 32'(acc_n - a0), 1);
        check("mr_data2", 32'(last_acc), 32'h81);

`ifdef UART_RX_PARITY_EN
        check("par_none", 32'(pe_n), 0);
        a0 = acc_n;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check("par_bad", 32'(pe_n), 1);
        check("par_bad_d", 32'(last_acc), 32'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check("par_ok", 32'(pe_n), 1);
        check("par_acc", 32'(acc_n - a0), 2);
`else
        check("par_tied", 32'(pe_n), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
